// File: rtl/fp_pkg.sv
// Shared widths, constants and the normalisation case tag for the fp add/sub back end.
package fp_pkg;

  localparam int DATA_W = 32;
  localparam int MENT_W = 23;
  localparam int EXPO_W = 8;
  localparam int LZC_W  = $clog2(MENT_W) + 1;
  localparam int BIAS   = 127;
  localparam logic [EXPO_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    NORM  = 2'd0,
    CARRY = 2'd1,
    ZERO  = 2'd2
  } case_tag_e;

endpackage

// File: rtl/fp_norm_shifter.sv
// Combinational renormaliser: right shift by one on carry-out, otherwise left shift
// by the leading-zero count, with the matching exponent adjustment.
module fp_norm_shifter
  import fp_pkg::*;
#(
  parameter int MENT_WIDTH = MENT_W,
  parameter int EXPO_WIDTH = EXPO_W,
  parameter int LZC_WIDTH  = $clog2(MENT_WIDTH) + 1
) (
  input  logic [MENT_WIDTH+1:0] sum,
  input  logic [LZC_WIDTH-1:0]  lzc,
  input  logic [EXPO_WIDTH-1:0] expo,
  output logic [MENT_WIDTH-1:0] mant,
  output logic [EXPO_WIDTH+1:0] exp_wide,
  output case_tag_e             tag
);

  localparam int EW = EXPO_WIDTH + 2;

  logic [EW-1:0]         exp_ext;
  logic [EW-1:0]         lzc_ext;
  logic [MENT_WIDTH-1:0] shl;

  assign exp_ext = {2'b00, expo};
  assign lzc_ext = EW'(lzc);
  // Bits above the stored field fall off, so only the low part of the sum matters here.
  assign shl     = sum[MENT_WIDTH-1:0] << lzc;

  always_comb begin
    mant     = '0;
    exp_wide = '0;
    tag      = NORM;
    if (sum[MENT_WIDTH+1]) begin
      tag      = CARRY;
      mant     = sum[MENT_WIDTH:1];
      exp_wide = exp_ext + EW'(1);
    end else if (lzc == LZC_WIDTH'(MENT_WIDTH + 1)) begin
      tag = ZERO;
    end else begin
      mant     = shl;
      exp_wide = exp_ext - lzc_ext;
    end
  end

endmodule

// File: rtl/fp_add_normalize_pack.sv
// Two-stage normalise/pack back end of the single-precision adder with a
// valid/ready handshake; stage A holds the normalised operand, stage B the packed word.
module fp_add_normalize_pack
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int MENT_WIDTH = MENT_W,
  parameter int EXPO_WIDTH = EXPO_W
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            s_valid_in,
  output logic                            s_ready_out,
  input  logic                            sign_in,
  input  logic [EXPO_WIDTH-1:0]           exp_in,
  input  logic [MENT_WIDTH+1:0]           sum_in,
  input  logic [$clog2(MENT_WIDTH):0]     lzc_in,
  output logic                            m_valid_out,
  input  logic                            m_ready_in,
  output logic [DATA_WIDTH-1:0]           result_out,
  output logic                            zero_out,
  output logic                            overflow_out,
  output logic                            underflow_out
);

  localparam int LZC_WIDTH = $clog2(MENT_WIDTH) + 1;
  localparam int EW        = EXPO_WIDTH + 2;
  localparam logic [EW-1:0] EXP_SAT = EW'((2 ** EXPO_WIDTH) - 1);

  logic                  v_a;
  logic                  sign_a;
  logic [MENT_WIDTH-1:0] mant_a;
  logic [EW-1:0]         exp_a;
  case_tag_e             tag_a;

  logic                  v_b;

  logic [MENT_WIDTH-1:0] mant_n;
  logic [EW-1:0]         exp_n;
  case_tag_e             tag_n;

  logic [DATA_WIDTH-1:0] pack_result;
  logic                  pack_zero;
  logic                  pack_ovf;
  logic                  pack_unf;
  logic                  adv_b;

  fp_norm_shifter #(
    .MENT_WIDTH (MENT_WIDTH),
    .EXPO_WIDTH (EXPO_WIDTH),
    .LZC_WIDTH  (LZC_WIDTH)
  ) u_shifter (
    .sum      (sum_in),
    .lzc      (lzc_in),
    .expo     (exp_in),
    .mant     (mant_n),
    .exp_wide (exp_n),
    .tag      (tag_n)
  );

  // Stage B frees when empty or draining; A can then always refill.
  assign adv_b       = !v_b || m_ready_in;
  assign s_ready_out = adv_b || !v_a;
  assign m_valid_out = v_b;

  // exp_a is two's complement: the sign bit marks an exponent that went below zero.
  always_comb begin
    pack_result = {sign_a, {(DATA_WIDTH-1){1'b0}}};
    pack_zero   = 1'b0;
    pack_ovf    = 1'b0;
    pack_unf    = 1'b0;
    if (tag_a == ZERO) begin
      pack_zero = 1'b1;
    end else if (exp_a[EW-1] || (exp_a == '0)) begin
      pack_unf  = 1'b1;
      pack_zero = 1'b1;
    end else if (exp_a >= EXP_SAT) begin
      pack_ovf    = 1'b1;
      pack_result = {sign_a, EXP_MAX, {MENT_WIDTH{1'b0}}};
    end else begin
      pack_result = {sign_a, exp_a[EXPO_WIDTH-1:0], mant_a};
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      v_a           <= 1'b0;
      sign_a        <= 1'b0;
      mant_a        <= '0;
      exp_a         <= '0;
      tag_a         <= NORM;
      v_b           <= 1'b0;
      result_out    <= '0;
      zero_out      <= 1'b0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      if (s_ready_out) begin
        v_a <= s_valid_in;
        if (s_valid_in) begin
          sign_a <= sign_in;
          mant_a <= mant_n;
          exp_a  <= exp_n;
          tag_a  <= tag_n;
        end
      end
      if (adv_b) begin
        v_b <= v_a;
        if (v_a) begin
          result_out    <= pack_result;
          zero_out      <= pack_zero;
          overflow_out  <= pack_ovf;
          underflow_out <= pack_unf;
        end
      end
    end
  end

endmodule

// File: doc/fp_add_normalize_pack.md
# fp_add_normalize_pack

Back-end stage of the pipelined single-precision add/sub datapath: consumes the raw mantissa sum, the larger exponent, the result sign and the leading-zero count produced by the addition control unit, and emits a packed IEEE-754 word. It renormalises (right shift on carry, left shift by the leading-zero count), adjusts and range-checks the exponent, and packs sign/exponent/mantissa. It sits between mantissa addition and the top-level result port, with a valid/ready handshake and 2-stage internal pipelining.

## Interface
Parameters:
- DATA_WIDTH, 32, packed result width
- MENT_WIDTH, 23, stored mantissa bits
- EXPO_WIDTH, 8, exponent bits

Ports (one clock; reset is synchronous and active-low):
- clk_in  input  1  clock, all state on rising edge
- rst_n_in  input  1  synchronous active-low reset
- s_valid_in  input  1  upstream operand set valid
- s_ready_out  output  1  stage can accept this cycle
- sign_in  input  1  result sign from control unit
- exp_in  input  EXPO_WIDTH  larger (aligned) biased exponent
- sum_in  input  MENT_WIDTH+2  {carry, hidden, mantissa} sum magnitude
- lzc_in  input  $clog2(MENT_WIDTH)+1  leading zeros of sum_in[MENT_WIDTH:0], 0..MENT_WIDTH+1
- m_valid_out  output  1  result valid
- m_ready_in  input  1  downstream accepts
- result_out  output  DATA_WIDTH  packed IEEE-754 result
- zero_out  output  1  result is (signed) zero
- overflow_out  output  1  result saturated to infinity
- underflow_out  output  1  result flushed to zero

## Operation
- Stage A (normalise), on accept (s_valid_in && s_ready_out):
  - carry = sum_in[MENT_WIDTH+1]=1: mant = sum_in >> 1, exp_wide = exp_in + 1.
  - else lzc_in = MENT_WIDTH+1 (sum zero): zero case.
  - else: mant = sum_in << lzc_in, exp_wide = exp_in − lzc_in (EXPO_WIDTH+2 bits, signed).
  - Registers sign, mant[MENT_WIDTH-1:0], exp_wide, case tag.
- Stage B (pack):
  - zero case: result {sign,0,0}, zero_out=1.
  - exp_wide ≤ 0: flush: {sign,0,0}, underflow_out=1, zero_out=1.
  - exp_wide ≥ 2^EXPO_WIDTH−1: infinity {sign,all-ones,0}, overflow_out=1.
  - else {sign, exp_wide[EXPO_WIDTH-1:0], mant}.
- Rounding: truncation (bits shifted out on carry are dropped). No denormal output.
- Flags are mutually exclusive except underflow implies zero.
- Stall: pipeline advances only when the downstream slot frees; s_ready_out = !vB || m_ready_in || !vA (no bubble lost; capacity 2).

## Timing
- Reset (rst_n_in=0 at edge): vA=vB=0, m_valid_out=0, result_out=0, all flags 0; s_ready_out=1 next cycle. Reset mid-stall discards both in-flight results.
- Latency: 2 cycles accept→m_valid_out with m_ready_in held 1; throughput 1/cycle.
- m_valid_out && !m_ready_in: result_out and flags held stable until accepted.
- Simultaneous accept at input and handoff at output in same cycle: both occur, no loss/duplication.
- s_ready_out combinational from state and m_ready_in only; no path from s_valid_in.
- Inputs not sampled when s_valid_in=0; outputs retain last value when m_valid_out=0.

## Structure
- Shared package fp_pkg: DATA/MENT/EXPO widths, EXP_MAX (all-ones), BIAS (127), LZC width, case-tag enum {NORM, CARRY, ZERO}.
- One sub-module: fp_norm_shifter (combinational: carry right-shift / lzc left-shift + exponent adjust), instanced in stage A.
- Handshake/stall logic and stage registers in top.

## Test plan
- 1.5+1.5: sign 0, exp_in 8'h7F, sum_in 25'h1800000, lzc 0 → result 32'h40400000 after 2 cycles, flags 0.
- 1.0−0.75: exp_in 8'h7F, sum_in 25'h0200000, lzc 2 → 32'h3E800000.
- Exact cancel: sum_in 0, lzc 24, sign 0 → 32'h00000000, zero_out=1.
- Overflow: exp_in 8'hFE, sum_in 25'h1000000 → 32'h7F800000, overflow_out=1; underflow: sign 1, exp_in 2, sum_in 25'h0100000, lzc 3 → 32'h80000000, underflow_out=1, zero_out=1.
- Backpressure: m_ready_in=0, push 3 back-to-back → 2 accepted, s_ready_out=0 on third, result_out stable; release → results drain in order, third then accepted.
- Reset with two results in flight → m_valid_out=0 next cycle, nothing emitted afterward.
